// File: rtl/core_bus_ctrl.sv
// Purpose : external multiplexed-bus controller; ALE address phase, then one PSEN_b/RD_b/WR_b strobe, EA_b synchronizer.
// Latency : request sampled at edge 0 -> ADDR cycle 1, LATCH 2, STROBE 3..3+WAIT_CYCLES, HOLD (rdy pulse) 4+WAIT_CYCLES.
// Backpr. : none; requests are level-held and ignored outside IDLE; one turnaround IDLE cycle follows every HOLD.
//
// Ports:
//   bus_ctrl_clk_i / bus_ctrl_rst_b_i            clock, async active-low reset
//   bus_ctrl_ext_{rom_rd,ram_rd,ram_wr}_b_i      active-low access requests (write > RAM read > ROM read)
//   bus_ctrl_addr_i / bus_ctrl_data_i            access address / write data, captured when a request wins
//   bus_ctrl_data_o / bus_ctrl_rdy_o             last read data / one-cycle completion pulse
//   bus_ctrl_ea_b_pin_i / bus_ctrl_ea_b_o        raw EA_b pin / EA_b after a 2-flop synchronizer
//   bus_ctrl_ale_o, _psen_b_o, _rd_b_o, _wr_b_o  bus control pins
//   bus_ctrl_p0_o / _p0_oe_o / _p0_i, _p2_o      multiplexed address/data port, high address port
module core_bus_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        bus_ctrl_clk_i,
    input  logic        bus_ctrl_rst_b_i,
    input  logic        bus_ctrl_ext_rom_rd_b_i,
    input  logic        bus_ctrl_ext_ram_rd_b_i,
    input  logic        bus_ctrl_ext_ram_wr_b_i,
    input  logic [15:0] bus_ctrl_addr_i,
    input  logic [7:0]  bus_ctrl_data_i,
    output logic [7:0]  bus_ctrl_data_o,
    output logic        bus_ctrl_rdy_o,
    output logic        bus_ctrl_ea_b_o,
    input  logic        bus_ctrl_ea_b_pin_i,
    output logic        bus_ctrl_ale_o,
    output logic        bus_ctrl_psen_b_o,
    output logic        bus_ctrl_rd_b_o,
    output logic        bus_ctrl_wr_b_o,
    output logic [7:0]  bus_ctrl_p0_o,
    output logic        bus_ctrl_p0_oe_o,
    input  logic [7:0]  bus_ctrl_p0_i,
    output logic [7:0]  bus_ctrl_p2_o
);

    // Strobe length counter start value; legal WAIT_CYCLES range is 0..7.
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_LATCH  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ACC_ROM = 2'd0,
        ACC_RD  = 2'd1,
        ACC_WR  = 2'd2
    } acc_t;

    state_t      state_q;
    state_t      state_nxt;
    acc_t        acc_q;
    logic [15:0] addr_q;
    logic [7:0]  wdat_q;
    logic [2:0]  wait_cnt_q;
    logic        turn_q;
    logic        req_any;
    logic        start;
    logic [15:0] addr_eff;
    logic [1:0]  ea_sync_q;
    logic [7:0]  rdat_q;

    // Registered pin/status outputs and their next values.
    logic        ale_q,    ale_nxt;
    logic        psen_b_q, psen_b_nxt;
    logic        rd_b_q,   rd_b_nxt;
    logic        wr_b_q,   wr_b_nxt;
    logic [7:0]  p0_q,     p0_nxt;
    logic        p0_oe_q,  p0_oe_nxt;
    logic [7:0]  p2_q,     p2_nxt;
    logic        rdy_q,    rdy_nxt;

    assign req_any = ~(bus_ctrl_ext_rom_rd_b_i & bus_ctrl_ext_ram_rd_b_i & bus_ctrl_ext_ram_wr_b_i);

    // The cycle right after HOLD is a turnaround: the requester is still
    // releasing its line there, so it is never sampled as a new request.
    assign start = (state_q == S_IDLE) && !turn_q && req_any;

    // On the IDLE->ADDR transition the address registers are loading in the
    // same edge, so the address phase is driven straight from the input.
    assign addr_eff = (state_q == S_IDLE) ? bus_ctrl_addr_i : addr_q;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge bus_ctrl_clk_i or negedge bus_ctrl_rst_b_i) begin
        if (!bus_ctrl_rst_b_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   if (start) state_nxt = S_ADDR;
            S_ADDR:   state_nxt = S_LATCH;
            S_LATCH:  state_nxt = S_STROBE;
            S_STROBE: if (wait_cnt_q == 3'd0) state_nxt = S_HOLD;
            S_HOLD:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM output logic: next pin values decoded from the next state, so
    // the registered pins line up with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        ale_nxt    = 1'b0;
        psen_b_nxt = 1'b1;
        rd_b_nxt   = 1'b1;
        wr_b_nxt   = 1'b1;
        p0_nxt     = p0_q;
        p0_oe_nxt  = 1'b0;
        p2_nxt     = p2_q;
        rdy_nxt    = 1'b0;
        case (state_nxt)
            S_ADDR: begin
                ale_nxt   = 1'b1;
                p0_nxt    = addr_eff[7:0];
                p0_oe_nxt = 1'b1;
                p2_nxt    = addr_eff[15:8];
            end
            S_LATCH: begin
                p0_oe_nxt = 1'b1;
            end
            S_STROBE: begin
                case (acc_q)
                    ACC_WR: begin
                        wr_b_nxt  = 1'b0;
                        p0_nxt    = wdat_q;
                        p0_oe_nxt = 1'b1;
                    end
                    ACC_RD:  rd_b_nxt   = 1'b0;
                    default: psen_b_nxt = 1'b0;
                endcase
            end
            S_HOLD: begin
                rdy_nxt = 1'b1;
                // Write data stays on P0 through HOLD for hold time.
                if (acc_q == ACC_WR) p0_oe_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge bus_ctrl_clk_i or negedge bus_ctrl_rst_b_i) begin
        if (!bus_ctrl_rst_b_i) begin
            ale_q    <= 1'b0;
            psen_b_q <= 1'b1;
            rd_b_q   <= 1'b1;
            wr_b_q   <= 1'b1;
            p0_q     <= 8'h00;
            p0_oe_q  <= 1'b0;
            p2_q     <= 8'h00;
            rdy_q    <= 1'b0;
        end else begin
            ale_q    <= ale_nxt;
            psen_b_q <= psen_b_nxt;
            rd_b_q   <= rd_b_nxt;
            wr_b_q   <= wr_b_nxt;
            p0_q     <= p0_nxt;
            p0_oe_q  <= p0_oe_nxt;
            p2_q     <= p2_nxt;
            rdy_q    <= rdy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request capture, strobe counter, turnaround flag, read data
    // ------------------------------------------------------------------
    always_ff @(posedge bus_ctrl_clk_i or negedge bus_ctrl_rst_b_i) begin
        if (!bus_ctrl_rst_b_i) begin
            acc_q      <= ACC_ROM;
            addr_q     <= 16'h0000;
            wdat_q     <= 8'h00;
            wait_cnt_q <= 3'd0;
            turn_q     <= 1'b0;
            rdat_q     <= 8'h00;
        end else begin
            if (start) begin
                if (!bus_ctrl_ext_ram_wr_b_i) begin
                    acc_q <= ACC_WR;
                end else if (!bus_ctrl_ext_ram_rd_b_i) begin
                    acc_q <= ACC_RD;
                end else begin
                    acc_q <= ACC_ROM;
                end
                addr_q <= bus_ctrl_addr_i;
                wdat_q <= bus_ctrl_data_i;
            end

            // Counter is armed in LATCH and counts down the extra strobe cycles.
            if (state_q == S_LATCH) begin
                wait_cnt_q <= WAIT_INIT;
            end else if ((state_q == S_STROBE) && (wait_cnt_q != 3'd0)) begin
                wait_cnt_q <= wait_cnt_q - 3'd1;
            end

            turn_q <= (state_q == S_HOLD);

            // Read data is taken on the edge that ends the strobe.
            if ((state_q == S_STROBE) && (wait_cnt_q == 3'd0) && (acc_q != ACC_WR)) begin
                rdat_q <= bus_ctrl_p0_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // EA_b synchronizer; resets to the "external access disabled" level.
    // ------------------------------------------------------------------
    always_ff @(posedge bus_ctrl_clk_i or negedge bus_ctrl_rst_b_i) begin
        if (!bus_ctrl_rst_b_i) begin
            ea_sync_q <= 2'b11;
        end else begin
            ea_sync_q <= {ea_sync_q[0], bus_ctrl_ea_b_pin_i};
        end
    end

    assign bus_ctrl_data_o   = rdat_q;
    assign bus_ctrl_rdy_o    = rdy_q;
    assign bus_ctrl_ea_b_o   = ea_sync_q[1];
    assign bus_ctrl_ale_o    = ale_q;
    assign bus_ctrl_psen_b_o = psen_b_q;
    assign bus_ctrl_rd_b_o   = rd_b_q;
    assign bus_ctrl_wr_b_o   = wr_b_q;
    assign bus_ctrl_p0_o     = p0_q;
    assign bus_ctrl_p0_oe_o  = p0_oe_q;
    assign bus_ctrl_p2_o     = p2_q;

endmodule

// File: tb/tb_core_bus_ctrl.sv
// Purpose : self-checking bench for core_bus_ctrl (WAIT_CYCLES 1, plus 0 and 7 instances on shared stimulus).
// Latency : cycle k is the interval after the k-th rising edge following the request-sampling edge 0.
// Backpr. : the bench acts as a requester that releases its request when rdy is seen.
module tb_core_bus_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rom_b, rrd_b, rwr_b;
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic        ea_pin;
    logic [7:0]  rd_val;
    logic [7:0]  p0_in;

    // WAIT_CYCLES=1 instance
    logic [7:0] m_dat, m_p0, m_p2;
    logic       m_rdy, m_ea, m_ale, m_psen_b, m_rd_b, m_wr_b, m_oe;
    // WAIT_CYCLES=0 instance
    logic [7:0] z_dat, z_p0, z_p2;
    logic       z_rdy, z_ea, z_ale, z_psen_b, z_rd_b, z_wr_b, z_oe;
    // WAIT_CYCLES=7 instance
    logic [7:0] s_dat, s_p0, s_p2;
    logic       s_rdy, s_ea, s_ale, s_psen_b, s_rd_b, s_wr_b, s_oe;

    // External memory model: drives the read value only while the main DUT strobes a read.
    assign p0_in = (!m_psen_b || !m_rd_b) ? rd_val : ~rd_val;

    core_bus_ctrl #(.WAIT_CYCLES(1)) u_dut (
        .bus_ctrl_clk_i(clk), .bus_ctrl_rst_b_i(rst_n),
        .bus_ctrl_ext_rom_rd_b_i(rom_b), .bus_ctrl_ext_ram_rd_b_i(rrd_b), .bus_ctrl_ext_ram_wr_b_i(rwr_b),
        .bus_ctrl_addr_i(addr), .bus_ctrl_data_i(wdat), .bus_ctrl_data_o(m_dat), .bus_ctrl_rdy_o(m_rdy),
        .bus_ctrl_ea_b_o(m_ea), .bus_ctrl_ea_b_pin_i(ea_pin), .bus_ctrl_ale_o(m_ale),
        .bus_ctrl_psen_b_o(m_psen_b), .bus_ctrl_rd_b_o(m_rd_b), .bus_ctrl_wr_b_o(m_wr_b),
        .bus_ctrl_p0_o(m_p0), .bus_ctrl_p0_oe_o(m_oe), .bus_ctrl_p0_i(p0_in), .bus_ctrl_p2_o(m_p2)
    );

    core_bus_ctrl #(.WAIT_CYCLES(0)) u_dut_w0 (
        .bus_ctrl_clk_i(clk), .bus_ctrl_rst_b_i(rst_n),
        .bus_ctrl_ext_rom_rd_b_i(rom_b), .bus_ctrl_ext_ram_rd_b_i(rrd_b), .bus_ctrl_ext_ram_wr_b_i(rwr_b),
        .bus_ctrl_addr_i(addr), .bus_ctrl_data_i(wdat), .bus_ctrl_data_o(z_dat), .bus_ctrl_rdy_o(z_rdy),
        .bus_ctrl_ea_b_o(z_ea), .bus_ctrl_ea_b_pin_i(ea_pin), .bus_ctrl_ale_o(z_ale),
        .bus_ctrl_psen_b_o(z_psen_b), .bus_ctrl_rd_b_o(z_rd_b), .bus_ctrl_wr_b_o(z_wr_b),
        .bus_ctrl_p0_o(z_p0), .bus_ctrl_p0_oe_o(z_oe), .bus_ctrl_p0_i(p0_in), .bus_ctrl_p2_o(z_p2)
    );

    core_bus_ctrl #(.WAIT_CYCLES(7)) u_dut_w7 (
        .bus_ctrl_clk_i(clk), .bus_ctrl_rst_b_i(rst_n),
        .bus_ctrl_ext_rom_rd_b_i(rom_b), .bus_ctrl_ext_ram_rd_b_i(rrd_b), .bus_ctrl_ext_ram_wr_b_i(rwr_b),
        .bus_ctrl_addr_i(addr), .bus_ctrl_data_i(wdat), .bus_ctrl_data_o(s_dat), .bus_ctrl_rdy_o(s_rdy),
        .bus_ctrl_ea_b_o(s_ea), .bus_ctrl_ea_b_pin_i(ea_pin), .bus_ctrl_ale_o(s_ale),
        .bus_ctrl_psen_b_o(s_psen_b), .bus_ctrl_rd_b_o(s_rd_b), .bus_ctrl_wr_b_o(s_wr_b),
        .bus_ctrl_p0_o(s_p0), .bus_ctrl_p0_oe_o(s_oe), .bus_ctrl_p0_i(p0_in), .bus_ctrl_p2_o(s_p2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entry: which access should complete, its data_o and its rdy cycle.
    typedef struct {
        logic [1:0] kind;   // 0 ROM, 1 RAM read, 2 RAM write
        logic [7:0] dat;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    // Per-cycle recordings (bit k = cycle k) of one access.
    logic [15:0] r_ale, r_psen, r_rd, r_wr, r_oe, r_rdy;
    logic [15:0] r0_psen, r0_rdy, r7_psen, r7_rdy;
    logic [7:0]  r_p0 [16];
    logic [7:0]  r_p2 [16];
    logic [7:0]  r_dat [16];

    task automatic idle(input int n);
        rom_b = 1'b1; rrd_b = 1'b1; rwr_b = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Launch one request (active-low levels) and record cycles 1..15; release on rdy.
    task automatic run_access(input logic rom, input logic rrd, input logic rwr,
                              input logic [15:0] a, input logic [7:0] wd);
        @(negedge clk);
        rom_b = rom; rrd_b = rrd; rwr_b = rwr; addr = a; wdat = wd;
        r_ale = '0; r_psen = '0; r_rd = '0; r_wr = '0; r_oe = '0; r_rdy = '0;
        r0_psen = '0; r0_rdy = '0; r7_psen = '0; r7_rdy = '0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            r_ale[k] = m_ale;  r_psen[k] = ~m_psen_b; r_rd[k] = ~m_rd_b; r_wr[k] = ~m_wr_b;
            r_oe[k]  = m_oe;   r_rdy[k]  = m_rdy;
            r0_psen[k] = ~z_psen_b; r0_rdy[k] = z_rdy;
            r7_psen[k] = ~s_psen_b; r7_rdy[k] = s_rdy;
            r_p0[k] = m_p0; r_p2[k] = m_p2; r_dat[k] = m_dat;
            if (m_rdy || k == 8) begin
                rom_b = 1'b1; rrd_b = 1'b1; rwr_b = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_ale, m_psen_b, m_rd_b, m_wr_b, m_oe, m_rdy, m_ea} !== 7'b0111001)
            $display("FAIL reset_ctrl: got %b expected %b", {m_ale, m_psen_b, m_rd_b, m_wr_b, m_oe, m_rdy, m_ea}, 7'b0111001);
        else n_pass++;
        n_checks++;
        if ({m_p0, m_p2, m_dat} !== 24'h000000)
            $display("FAIL reset_data: got %h expected %h", {m_p0, m_p2, m_dat}, 24'h000000);
        else n_pass++;
        rst_n = 1'b1;
        idle(3);
    endtask

    // Pop scoreboard entries against the rdy pulses of the last recording.
    task automatic check_completions(input string nm);
        exp_t e;
        for (int k = 1; k < 16; k++) begin
            if (r_rdy[k]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s_extra_rdy: got rdy in cycle %0d expected none", nm, k);
                end else begin
                    e = exp_q.pop_front();
                    if (r_dat[k] !== e.dat || k != e.cyc)
                        $display("FAIL %s_rdy: got data %h cycle %0d expected data %h cycle %0d", nm, r_dat[k], k, e.dat, e.cyc);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_missing_rdy: %0d completions outstanding expected 0", nm, exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_rom_read;
        rd_val = 8'hA5;
        exp_q.push_back('{kind: 2'd0, dat: 8'hA5, cyc: 5});
        run_access(1'b0, 1'b1, 1'b1, 16'h1234, 8'h00);
        n_checks++;
        if (r_ale !== 16'h0002) $display("FAIL rom_ale: got %h expected %h", r_ale, 16'h0002); else n_pass++;
        n_checks++;
        if ({r_p2[1], r_p0[1], r_p2[2], r_p0[2]} !== 32'h1234_1234)
            $display("FAIL rom_addr: got %h expected %h", {r_p2[1], r_p0[1], r_p2[2], r_p0[2]}, 32'h1234_1234);
        else n_pass++;
        n_checks++;
        if (r_psen !== 16'h0018) $display("FAIL rom_psen: got %h expected %h", r_psen, 16'h0018); else n_pass++;
        n_checks++;
        if (r_oe !== 16'h0006) $display("FAIL rom_oe: got %h expected %h", r_oe, 16'h0006); else n_pass++;
        n_checks++;
        if ((r_rd | r_wr) !== 16'h0000) $display("FAIL rom_rdwr: got %h expected %h", r_rd | r_wr, 16'h0000); else n_pass++;
        n_checks++;
        if (r_dat[4] !== 8'h00) $display("FAIL rom_early_data: got %h expected %h", r_dat[4], 8'h00); else n_pass++;
        check_completions("rom");
    endtask

    task automatic test_ram_write;
        exp_q.push_back('{kind: 2'd2, dat: 8'hA5, cyc: 5});  // data_o keeps the previous read
        run_access(1'b1, 1'b1, 1'b0, 16'h00F0, 8'h5C);
        n_checks++;
        if (r_wr !== 16'h0018) $display("FAIL wr_strobe: got %h expected %h", r_wr, 16'h0018); else n_pass++;
        n_checks++;
        if (r_oe !== 16'h003E) $display("FAIL wr_oe: got %h expected %h", r_oe, 16'h003E); else n_pass++;
        n_checks++;
        if ({r_p2[1], r_p0[1]} !== 16'h00F0) $display("FAIL wr_addr: got %h expected %h", {r_p2[1], r_p0[1]}, 16'h00F0); else n_pass++;
        n_checks++;
        if ({r_p0[3], r_p0[4], r_p0[5]} !== 24'h5C5C5C)
            $display("FAIL wr_data_hold: got %h expected %h", {r_p0[3], r_p0[4], r_p0[5]}, 24'h5C5C5C);
        else n_pass++;
        n_checks++;
        if ((r_psen | r_rd) !== 16'h0000) $display("FAIL wr_other_strobes: got %h expected %h", r_psen | r_rd, 16'h0000); else n_pass++;
        check_completions("wr");
    endtask

    task automatic test_priority;
        exp_t e;
        logic [1:0] cur;
        int viol;
        cur = 2'd3; viol = 0;
        exp_q.push_back('{kind: 2'd2, dat: 8'hA5, cyc: 5});
        exp_q.push_back('{kind: 2'd1, dat: 8'h3C, cyc: 12});
        exp_q.push_back('{kind: 2'd0, dat: 8'hC3, cyc: 19});
        @(negedge clk);
        rd_val = 8'h3C; addr = 16'h0010; wdat = 8'h77;
        rom_b = 1'b0; rrd_b = 1'b0; rwr_b = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (!m_wr_b) cur = 2'd2;
            if (!m_rd_b) cur = 2'd1;
            if (!m_psen_b) cur = 2'd0;
            if (32'(m_ale) + 32'(!m_psen_b) + 32'(!m_rd_b) + 32'(!m_wr_b) > 1) viol++;
            if (m_rdy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL prio_extra_rdy: got rdy in cycle %0d expected none", k);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.kind || m_dat !== e.dat || k != e.cyc)
                        $display("FAIL prio_order: got kind %0d data %h cycle %0d expected kind %0d data %h cycle %0d",
                                 cur, m_dat, k, e.kind, e.dat, e.cyc);
                    else n_pass++;
                    // Requester releases the served request in the rdy cycle.
                    case (e.kind)
                        2'd2: rwr_b = 1'b1;
                        2'd1: begin rrd_b = 1'b1; rd_val = 8'hC3; end
                        default: rom_b = 1'b1;
                    endcase
                end
            end
        end
        rom_b = 1'b1; rrd_b = 1'b1; rwr_b = 1'b1;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL prio_missing_rdy: %0d completions outstanding expected 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
        n_checks++;
        if (viol != 0) $display("FAIL prio_exclusive: got %0d overlapping cycles expected 0", viol); else n_pass++;
    endtask

    task automatic test_reset_mid_strobe;
        int nrdy, nale;
        nrdy = 0; nale = 0;
        @(negedge clk);
        rd_val = 8'h99; addr = 16'h2222; rrd_b = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (m_rd_b !== 1'b0) $display("FAIL rst_strobe_active: got rd_b %b expected %b", m_rd_b, 1'b0); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_rd_b, m_p0_oe_chk(), m_psen_b, m_wr_b, m_rdy} !== 5'b10110)
            $display("FAIL rst_async_pins: got %b expected %b", {m_rd_b, m_oe, m_psen_b, m_wr_b, m_rdy}, 5'b10110);
        else n_pass++;
        n_checks++;
        if (m_dat !== 8'h00) $display("FAIL rst_data_clear: got %h expected %h", m_dat, 8'h00); else n_pass++;
        rrd_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (m_rdy) nrdy++;
            if (m_ale || !m_rd_b) nale++;
        end
        n_checks++;
        if (nrdy != 0 || nale != 0)
            $display("FAIL rst_idle_after: got %0d rdy %0d bus cycles expected 0 0", nrdy, nale);
        else n_pass++;
        rd_val = 8'h5A;
        exp_q.push_back('{kind: 2'd0, dat: 8'h5A, cyc: 5});
        run_access(1'b0, 1'b1, 1'b1, 16'hABCD, 8'h00);
        check_completions("rst_recover");
    endtask

    function automatic logic m_p0_oe_chk();
        return m_oe;
    endfunction

    task automatic test_wait_widths;
        run_access(1'b0, 1'b1, 1'b1, 16'h0100, 8'h00);
        n_checks++;
        if (r0_psen !== 16'h0008) $display("FAIL w0_strobe: got %h expected %h", r0_psen, 16'h0008); else n_pass++;
        n_checks++;
        if (r0_rdy !== 16'h0010) $display("FAIL w0_rdy: got %h expected %h", r0_rdy, 16'h0010); else n_pass++;
        n_checks++;
        if (r7_psen !== 16'h07F8) $display("FAIL w7_strobe: got %h expected %h", r7_psen, 16'h07F8); else n_pass++;
        n_checks++;
        if (r7_rdy !== 16'h0800) $display("FAIL w7_rdy: got %h expected %h", r7_rdy, 16'h0800); else n_pass++;
    endtask

    task automatic test_ea_sync;
        logic lvl;
        for (int t = 0; t < 2; t++) begin
            lvl = (t == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            ea_pin = lvl;
            @(negedge clk);
            n_checks++;
            if (m_ea !== ~lvl) $display("FAIL ea_after1: got %b expected %b", m_ea, ~lvl); else n_pass++;
            @(negedge clk);
            n_checks++;
            if (m_ea !== lvl) $display("FAIL ea_after2: got %b expected %b", m_ea, lvl); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rom_b = 1'b1; rrd_b = 1'b1; rwr_b = 1'b1;
        addr = 16'h0000; wdat = 8'h00; ea_pin = 1'b1; rd_val = 8'h00;
        test_reset;
        test_rom_read;
        idle(20);
        test_ram_write;
        idle(20);
        test_priority;
        idle(20);
        test_reset_mid_strobe;
        idle(20);
        test_wait_widths;
        idle(20);
        test_ea_sync;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_bus_ctrl.md
# core_bus_ctrl

External bus controller that services the memory controller's external-access requests and drives the microcontroller's multiplexed external bus pins. It accepts active-low ROM-read, RAM-read and RAM-write requests with a 16-bit address and 8-bit write data. It runs a single multiplexed bus cycle: ALE address latch, then a PSEN_b, RD_b or WR_b strobe. It returns read data with a one-cycle ready pulse, and passes a synchronized EA_b pin back to the core.

## Interface

Parameters:
- WAIT_CYCLES, 1, extra strobe-low cycles beyond the first; legal range 0..7.

Ports:
- bus_ctrl_clk_i  in  1  single clock, rising edge.
- bus_ctrl_rst_b_i  in  1  reset, asynchronous, active-low.
- bus_ctrl_ext_rom_rd_b_i  in  1  ROM-read request, active-low level.
- bus_ctrl_ext_ram_rd_b_i  in  1  RAM-read request, active-low level.
- bus_ctrl_ext_ram_wr_b_i  in  1  RAM-write request, active-low level.
- bus_ctrl_addr_i  in  16  access address.
- bus_ctrl_data_i  in  8  write data.
- bus_ctrl_data_o  out  8  captured read data.
- bus_ctrl_rdy_o  out  1  one-cycle pulse; the access is complete.
- bus_ctrl_ea_b_o  out  1  EA_b pin after the synchronizer.
- bus_ctrl_ea_b_pin_i  in  1  EA_b pin, asynchronous.
- bus_ctrl_ale_o  out  1  address latch enable, active-high.
- bus_ctrl_psen_b_o  out  1  program store enable, active-low.
- bus_ctrl_rd_b_o  out  1  external RAM read strobe, active-low.
- bus_ctrl_wr_b_o  out  1  external RAM write strobe, active-low.
- bus_ctrl_p0_o  out  8  P0 output value: low address byte, or write data.
- bus_ctrl_p0_oe_o  out  1  P0 output enable; 1 means drive.
- bus_ctrl_p0_i  in  8  P0 pin input, used for read data.
- bus_ctrl_p2_o  out  8  high address byte.

## Operation

- The FSM has five states: IDLE, ADDR, LATCH, STROBE, HOLD.
- In IDLE, requests are sampled on every rising edge.
  - Priority: RAM write > RAM read > ROM read.
  - The winning request's type, bus_ctrl_addr_i and bus_ctrl_data_i are captured into internal registers. The FSM moves to ADDR.
  - Requests arriving in any other state are ignored until the FSM returns to IDLE.
- ADDR (1 cycle):
  - ale=1.
  - p0_o = addr[7:0], p0_oe=1.
  - p2_o = addr[15:8].
- LATCH (1 cycle): ale=0. P0 and P2 are held at the address.
- STROBE (1+WAIT_CYCLES cycles, counted by a 3-bit down-counter):
  - ROM read: psen_b=0, p0_oe=0.
  - RAM read: rd_b=0, p0_oe=0.
  - RAM write: wr_b=0, p0_o = captured write data, p0_oe=1.
  - P2 is held throughout.
- On the edge that ends STROBE, a read captures bus_ctrl_p0_i into bus_ctrl_data_o.
- HOLD (1 cycle):
  - All strobes are high.
  - A write keeps P0 driven with the write data (data hold time).
  - A read keeps p0_oe=0.
  - rdy_o=1. The FSM returns to IDLE next.
- In IDLE, p0_oe=0 and ale=0. P0 and P2 keep their last values.
- bus_ctrl_data_o holds its last read value until the next read completes. Writes do not change it.
- The requester must deassert its request in the cycle after rdy_o. A request still low in IDLE starts a new cycle; this is legal back-to-back operation.
- EA_b uses a 2-flop synchronizer from the pin to bus_ctrl_ea_b_o.
- All pin and status outputs are registered. No output is combinationally decoded from inputs.

## Timing

- Reset values:
  - FSM = IDLE.
  - ale=0, psen_b=1, rd_b=1, wr_b=1.
  - p0_oe=0, p0_o=0x00, p2_o=0x00.
  - data_o=0x00, rdy_o=0.
  - ea_b_o=1, and both synchronizer flops = 1.
- Latency, counting the request-sampling edge as edge 0:
  - ADDR in cycle 1, LATCH in cycle 2.
  - STROBE in cycles 3..3+WAIT_CYCLES.
  - HOLD (rdy_o=1) in cycle 4+WAIT_CYCLES. With the default WAIT_CYCLES=1, rdy_o is in cycle 5.
- Back-to-back: the earliest next sampling edge is the edge that ends HOLD+1 IDLE cycle. Bus period = 6+WAIT_CYCLES cycles.
- Strobes are mutually exclusive. ale and any strobe are never active in the same cycle.
- The p0_oe transition from 1 to 0 for a read happens at entry to STROBE, in the same cycle that psen_b/rd_b fall.
- Simultaneous requests: only the highest priority is served. The others are served in later cycles if still asserted.
- Reset asserted mid-cycle:
  - All strobes go high and p0_oe goes to 0 immediately (asynchronously).
  - No rdy_o pulse is generated. data_o clears.
- WAIT_CYCLES=0 gives a one-cycle strobe; the capture occurs at the end of that single cycle.

## Test plan

- Reset, then ROM read of addr 0x1234 with p0_i=0xA5 during STROBE, WAIT_CYCLES=1:
  - ale=1 with p0_o=0x34 and p2_o=0x12 in cycle 1.
  - psen_b low in cycles 3-4.
  - data_o=0xA5 and rdy_o=1 in cycle 5.
  - rd_b and wr_b stay high throughout.
- RAM write of 0x5C to 0x00F0:
  - wr_b low 2 cycles with p0_o=0x5C and p0_oe=1.
  - p0_o still 0x5C in HOLD.
  - data_o unchanged. One rdy_o pulse.
- All three requests low together at addr 0x0010: the write is served first, then the RAM read, then the ROM read. Three rdy_o pulses, periods of 7 cycles each.
- Reset pulled low during STROBE of a RAM read:
  - rd_b=1 and p0_oe=0 within the same cycle.
  - No rdy_o. FSM in IDLE after reset is released.
- WAIT_CYCLES=0 and WAIT_CYCLES=7 builds: the strobe width is 1 and 8 cycles respectively, and rdy_o lands in cycle 4 and cycle 11.
- Toggle ea_b_pin_i: bus_ctrl_ea_b_o follows after exactly 2 rising edges.
